// File: rtl/led_pattern_engine_pkg.sv
// led_pattern_pkg: shared constants and types for the LED pattern engine.
//   mode_e      : pattern mode encodings (bounce, wrap up, wrap down,
//                 binary count, fill bar)
//   DIR_UP/DN   : direction of the moving dot (UP = toward the MSB LED)
//   PWM_BITS    : width of the brightness input and the PWM counter
//   decode_mode : folds unused mode codes (5..7) onto bounce
package led_pattern_pkg;

  localparam int PWM_BITS = 4;

  typedef enum logic [2:0] {
    MODE_BOUNCE  = 3'd0,
    MODE_WRAP_UP = 3'd1,
    MODE_WRAP_DN = 3'd2,
    MODE_COUNT   = 3'd3,
    MODE_FILL    = 3'd4
  } mode_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic mode_e decode_mode(input logic [2:0] m);
    if (m > 3'd4) return MODE_BOUNCE;
    return mode_e'(m);
  endfunction

endpackage

// File: rtl/led_pattern_engine_if.sv
// led_pattern_if: switch-side controls and LED-side outputs of the engine.
//   en, mode, speed, brightness : control inputs from the board switches
//   led, pos, dir               : registered LED drive and dot/bar status
//   step, wrap                  : one-cycle status pulses
// Modports: master drives the controls (board/testbench), slave is the engine.
interface led_pattern_if #(
  parameter int NUM_LEDS = 16,
  parameter int POS_W    = $clog2(NUM_LEDS)
);
  import led_pattern_pkg::*;

  logic                en;
  logic [2:0]          mode;
  logic [3:0]          speed;
  logic [PWM_BITS-1:0] brightness;
  logic [NUM_LEDS-1:0] led;
  logic [POS_W-1:0]    pos;
  logic                dir;
  logic                step;
  logic                wrap;

  modport master (
    output en, mode, speed, brightness,
    input  led, pos, dir, step, wrap
  );

  modport slave (
    input  en, mode, speed, brightness,
    output led, pos, dir, step, wrap
  );

endinterface

// File: rtl/led_pattern_engine_step_prescaler.sv
// step_prescaler: divides the clock down to pattern steps.
//   clk, rst : clock and synchronous active-high reset
//   en_i     : 1 = count, 0 = hold the divider where it is
//   speed_i  : step period = max(1, CLKS_PER_STEP >> speed_i)
//   step_o   : high during the last cycle of each step period
module step_prescaler #(
  parameter int CLKS_PER_STEP = 25_000_000,
  parameter int DIV_W         = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [3:0] speed_i,
  output logic       step_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] period_q, period_d;

  function automatic logic [DIV_W-1:0] period_for(input logic [3:0] spd);
    logic [DIV_W-1:0] p;
    p = DIV_W'(CLKS_PER_STEP) >> spd;
    if (p == '0) p = DIV_W'(1);
    return p;
  endfunction

  // Reset suppresses the pulse so nothing downstream advances in that cycle.
  assign step_o = en_i && !rst && (div_q == period_q - DIV_W'(1));

  // The period is only re-latched as the divider returns to zero, so a speed
  // change always lets the step in progress finish at its old length.
  always_comb begin
    div_d    = div_q;
    period_d = period_q;
    if (step_o) begin
      div_d    = '0;
      period_d = period_for(speed_i);
    end else if (en_i) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      period_q <= period_for(speed_i);
    end else begin
      div_q    <= div_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: parametrised LED pattern generator with PWM brightness.
//   clk, rst : clock and synchronous active-high reset
//   ctrl_io  : led_pattern_if slave (en/mode/speed/brightness in;
//              led/pos/dir/step/wrap out)
// Optional macro LED_PATTERN_TRAIL_EN adds a decaying trail of the last
// TRAIL_LEN dot positions in the bounce/wrap modes.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS      = 16,
  parameter int CLKS_PER_STEP = 25_000_000,
  parameter int DIV_W         = 30,
  parameter int TRAIL_LEN     = 3
) (
  input logic          clk,
  input logic          rst,
  led_pattern_if.slave ctrl_io
);

  localparam int               POS_W   = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);

  if (NUM_LEDS < 2 || TRAIL_LEN < 1 || TRAIL_LEN > 4) begin : g_bad_cfg
    $error("led_pattern_engine: NUM_LEDS must be >= 2 and TRAIL_LEN 1..4");
  end

  logic                step_pulse;
  logic                wrap_hit;
  mode_e               mode_eff;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_q, dir_d;
  logic [NUM_LEDS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic [NUM_LEDS-1:0] pattern;
  logic [PWM_BITS-1:0] level [NUM_LEDS];

  step_prescaler #(
    .CLKS_PER_STEP(CLKS_PER_STEP),
    .DIV_W        (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ctrl_io.en),
    .speed_i(ctrl_io.speed),
    .step_o (step_pulse)
  );

  assign mode_eff = decode_mode(ctrl_io.mode);

  // Next pattern position/direction/count; only evaluated on a step. wrap_hit
  // marks the bounce reversal, wrap-around, count overflow or bar clear.
  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    wrap_hit = 1'b0;
    if (step_pulse) begin
      case (mode_eff)
        MODE_WRAP_UP: begin
          dir_d = DIR_UP;
          if (pos_q >= POS_MAX) begin
            pos_d    = '0;
            wrap_hit = 1'b1;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
        MODE_WRAP_DN: begin
          dir_d = DIR_DN;
          if (pos_q == '0) begin
            pos_d    = POS_MAX;
            wrap_hit = 1'b1;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
        MODE_COUNT: begin
          cnt_d    = cnt_q + NUM_LEDS'(1);
          wrap_hit = &cnt_q;
        end
        MODE_FILL: begin
          if (pos_q >= POS_MAX) begin
            pos_d    = '0;
            wrap_hit = 1'b1;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end
        default: begin
          if (dir_q == DIR_UP) begin
            if (pos_q >= POS_MAX) begin
              dir_d    = DIR_DN;
              pos_d    = POS_MAX - POS_W'(1);
              wrap_hit = 1'b1;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              dir_d    = DIR_UP;
              pos_d    = POS_W'(1);
              wrap_hit = 1'b1;
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
      endcase
    end
  end

  // The displayed pattern follows the live mode input so a mode switch is
  // visible immediately, while position/count only move on steps.
  always_comb begin
    pattern = '0;
    case (mode_eff)
      MODE_COUNT: pattern = cnt_q;
      MODE_FILL: begin
        for (int i = 0; i < NUM_LEDS; i++) pattern[i] = (POS_W'(i) <= pos_q);
      end
      default: pattern[pos_q] = 1'b1;
    endcase
  end

`ifdef LED_PATTERN_TRAIL_EN
  logic                 dot_mode;
  logic [POS_W-1:0]     hist_pos_q [TRAIL_LEN];
  logic [TRAIL_LEN-1:0] hist_vld_q;

  assign dot_mode = (mode_eff == MODE_BOUNCE) || (mode_eff == MODE_WRAP_UP) ||
                    (mode_eff == MODE_WRAP_DN);

  // Entry 0 is the newest history position; count and fill steps wipe it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld_q <= '0;
      for (int k = 0; k < TRAIL_LEN; k++) hist_pos_q[k] <= '0;
    end else if (step_pulse) begin
      if (dot_mode) begin
        hist_pos_q[0] <= pos_q;
        hist_vld_q[0] <= 1'b1;
        for (int k = 1; k < TRAIL_LEN; k++) begin
          hist_pos_q[k] <= hist_pos_q[k-1];
          hist_vld_q[k] <= hist_vld_q[k-1];
        end
      end else begin
        hist_vld_q <= '0;
      end
    end
  end
`endif

  // Per-LED PWM level: full brightness for lit pattern LEDs, halved once per
  // history age for trail LEDs, brightest contribution wins.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      level[i] = pattern[i] ? ctrl_io.brightness : '0;
`ifdef LED_PATTERN_TRAIL_EN
      if (dot_mode) begin
        for (int k = 0; k < TRAIL_LEN; k++) begin
          if (hist_vld_q[k] && (hist_pos_q[k] == POS_W'(i)) &&
              ((ctrl_io.brightness >> (k + 1)) > level[i])) begin
            level[i] = ctrl_io.brightness >> (k + 1);
          end
        end
      end
`endif
      led_d[i] = (pwm_q < level[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= DIR_UP;
      cnt_q <= '0;
      pwm_q <= '0;
      led_q <= '0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      pwm_q <= pwm_q + PWM_BITS'(1);
      led_q <= led_d;
    end
  end

  assign ctrl_io.led  = led_q;
  assign ctrl_io.pos  = pos_q;
  assign ctrl_io.dir  = dir_q;
  assign ctrl_io.step = step_pulse;
  assign ctrl_io.wrap = wrap_hit;

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED pattern generator: the next generation of the board's cylon block, with an arbitrary LED count and five pattern modes. It has an internal step prescaler with a speed shift and a PWM brightness stage. An optional decaying trail follows the lit dot. It sits between the board switches (mode/speed/brightness) and the LED pins, and exports step/position status for a seven-segment display driver.

## Interface
- NUM_LEDS, 16, number of LEDs driven (≥ 2)
- CLKS_PER_STEP, 25_000_000, clock cycles per pattern step at speed 0 (≥ 1)
- DIV_W, 30, width of the step prescaler counter
- TRAIL_LEN, 3, trail depth in steps (used only with trail compiled in, 1..4)
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  1 = pattern runs, 0 = prescaler and pattern frozen (PWM keeps running)
- mode  in  3  0 bounce, 1 wrap up, 2 wrap down, 3 binary count, 4 fill bar, 5–7 treated as 0
- speed  in  4  step period = max(1, CLKS_PER_STEP >> speed)
- brightness  in  4  PWM duty 0..15 of 16; 0 = dark
- led  out  NUM_LEDS  registered LED drive
- pos  out  $clog2(NUM_LEDS)  current dot/bar position
- dir  out  1  0 = moving up (toward MSB), 1 = down
- step  out  1  one-cycle pulse on each pattern step
- wrap  out  1  one-cycle pulse on bounce reversal, wrap-around, count overflow or bar clear

## Operation
- Prescaler: div counts 0..period−1 while en=1. step=1 in the cycle div==period−1; div then returns to 0. period is recomputed from speed only when div returns to 0, so a speed change finishes the current step first.
- mode is sampled on step. Pos, dir and count persist across mode changes. In bounce mode, pos is clamped to ≤ NUM_LEDS−1 (always true).
- Bounce (0):
  - dir=0, pos<N−1: pos+1.
  - dir=0, pos==N−1: dir←1, pos←N−2, wrap.
  - Mirror behaviour at pos 0 going down (dir←0, pos←1, wrap).
- Wrap up (1): dir←0; pos+1, and from N−1 go to 0 with wrap.
- Wrap down (2): dir←1; pos−1, and from 0 go to N−1 with wrap.
- Count (3): NUM_LEDS-bit cnt+1 and wrap when cnt goes from all-ones to 0. The displayed pattern is cnt.
- Fill (4): bar = bits 0..pos lit. pos+1, and from N−1 go to 0 with wrap (bar clears to single LED).
- PWM: 4-bit free-running pwm_cnt; level L is on when pwm_cnt < L. Lit pattern LEDs use L = brightness.
- Reset values: led 0, pos 0, dir 0, step 0, wrap 0, cnt 0, div 0, pwm_cnt 0, trail history invalid.

## Timing
- step and wrap are combinational off registered state and are high for exactly one clock.
- pos, dir and cnt update on the clock edge ending the step cycle.
- led is registered: it reflects pattern/pwm state one cycle after they change.
- Speed 0 with CLKS_PER_STEP=1: step every cycle.
- en deasserted on the step cycle: no step occurs, and div holds its value.
- rst overrides en and step in the same cycle. All state reaches its reset value on the next edge.

## Configuration
- LED_PATTERN_TRAIL_EN defined: modes 0–2 keep a history of the last TRAIL_LEN positions, shifted on each step.
  - History entry k (1 = newest) lights at level brightness >> k.
  - If an LED is both the current dot and a history entry, the brighter level wins.
  - History is invalidated on rst and on any step where mode is 3 or 4.
- Macro undefined: no history registers; only the current pattern is driven.

## Structure
- Package led_pattern_pkg: mode encodings (MODE_BOUNCE, MODE_WRAP_UP, MODE_WRAP_DN, MODE_COUNT, MODE_FILL), direction constants DIR_UP/DIR_DN, PWM_BITS=4.
- Sub-module step_prescaler: holds div, period latch and the speed shift, and outputs step. Position, count, trail and PWM logic stay in the top.

## Test plan
- NUM_LEDS=4, CLKS_PER_STEP=4, speed 0, mode 0, brightness 15, after rst → step every 4 cycles; pos sequence 0,1,2,3,2,1,0,1; wrap on the steps entering 2 (from 3) and 1 (from 0); dir toggles there.
- Mode 1 then mode 2, same config → pos 0,1,2,3,0 with wrap on 3→0; after switching, pos 3,2,1,0,3 with wrap on 0→3.
- Mode 3, CLKS_PER_STEP=1 → led counts 0x0..0xF (brightness 15, sampled when pwm_cnt<15); wrap on 0xF→0x0 at step 16.
- Speed changed from 0 to 2 mid-step with CLKS_PER_STEP=8 → current step completes at 8 cycles, following steps every 2 cycles. en=0 for 5 cycles → no step, div frozen.
- brightness 4, mode 4 → each lit LED is high exactly 4 of every 16 cycles; bar grows 0x1,0x3,0x7,0xF then back to 0x1 with wrap.
- rst asserted on a step cycle mid-pattern → next cycle pos 0, dir 0, led 0, no step or wrap. With LED_PATTERN_TRAIL_EN, brightness 8, TRAIL_LEN 2: after steps to pos 2, LED1 duty 4/16 and LED0 duty 2/16.
